gpio_avalon_ctrl: RTL and testbench

GPIO_AVALON_CTRL -- requirements
Module: gpio_avalon_ctrl

---
 rtl/gpio_avalon_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_gpio_avalon_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_avalon_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_avalon_ctrl
//  Description : Avalon-MM slave exposing slide switches, debounced push
//                buttons with press-edge capture and maskable interrupt, and
//                an LED register with set and toggle access.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_avalon_ctrl #(
    parameter int KEY_W      = 4,
    parameter int SW_W       = 8,
    parameter int LED_W      = 8,
    parameter int DEB_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    input  logic [KEY_W-1:0]  key_n,
    input  logic [SW_W-1:0]   sw,
    output logic [LED_W-1:0]  led,
    output logic              irq
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int              CNT_W     = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    localparam logic [2:0] ADDR_SW      = 3'd0;
    localparam logic [2:0] ADDR_KEY     = 3'd1;
    localparam logic [2:0] ADDR_LED     = 3'd2;
    localparam logic [2:0] ADDR_EDGE    = 3'd3;
    localparam logic [2:0] ADDR_MASK    = 3'd4;
    localparam logic [2:0] ADDR_LED_TGL = 3'd5;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [KEY_W-1:0] key_meta_q;
    logic [KEY_W-1:0] key_sync_q;
    logic [SW_W-1:0]  sw_meta_q;
    logic [SW_W-1:0]  sw_sync_q;

    logic [KEY_W-1:0] w_key_pressed;
    logic [KEY_W-1:0] w_key_deb;
    logic [KEY_W-1:0] w_key_rise;
    logic [KEY_W-1:0] w_edge_clr;

    logic [LED_W-1:0] led_q,   led_d;
    logic [KEY_W-1:0] edge_q,  edge_d;
    logic [KEY_W-1:0] mask_q,  mask_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             irq_q,   irq_d;

    logic             w_wr_led;
    logic             w_wr_tgl;
    logic             w_wr_edge;
    logic             w_wr_mask;

    // Upper writedata bits are intentionally dropped by narrow registers.
    logic             w_unused;
    assign w_unused = ^avs_writedata;

    // ------------------------------------------------------------------------
    // Input synchronizers; keys idle released (high), switches idle low
    // ------------------------------------------------------------------------
    // Two-flop synchronizers for every raw asynchronous input bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_meta_q <= '1;
            key_sync_q <= '1;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
        end else begin
            key_meta_q <= key_n;
            key_sync_q <= key_meta_q;
            sw_meta_q  <= sw;
            sw_sync_q  <= sw_meta_q;
        end
    end

    assign w_key_pressed = ~key_sync_q;

    // ------------------------------------------------------------------------
    // Per-key debounce: the counter measures how long the synchronized level
    // has disagreed with the debounced level; a full window commits it.
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < KEY_W; gi++) begin : g_key
        logic             deb_q, deb_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             rise;

        // Next debounced state, stability counter and press pulse.
        always_comb begin
            deb_d = deb_q;
            cnt_d = cnt_q;
            rise  = 1'b0;
            if (w_key_pressed[gi] == deb_q) begin
                cnt_d = '0;
            end else if (cnt_q == DEB_LAST) begin
                deb_d = w_key_pressed[gi];
                cnt_d = '0;
                rise  = w_key_pressed[gi];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Debounce state registers; reset abandons any pending window.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                deb_q <= 1'b0;
                cnt_q <= '0;
            end else begin
                deb_q <= deb_d;
                cnt_q <= cnt_d;
            end
        end

        assign w_key_deb[gi]  = deb_q;
        assign w_key_rise[gi] = rise;
    end

    // ------------------------------------------------------------------------
    // Register write decode
    // ------------------------------------------------------------------------
    assign w_wr_led   = avs_write && (avs_address == ADDR_LED);
    assign w_wr_tgl   = avs_write && (avs_address == ADDR_LED_TGL);
    assign w_wr_edge  = avs_write && (avs_address == ADDR_EDGE);
    assign w_wr_mask  = avs_write && (avs_address == ADDR_MASK);
    assign w_edge_clr = w_wr_edge ? avs_writedata[KEY_W-1:0] : '0;

    // Next values of the writable registers, edge latch and interrupt.
    always_comb begin
        led_d  = led_q;
        mask_d = mask_q;
        if (w_wr_led) begin
            led_d = avs_writedata[LED_W-1:0];
        end else if (w_wr_tgl) begin
            led_d = led_q ^ avs_writedata[LED_W-1:0];
        end
        if (w_wr_mask) begin
            mask_d = avs_writedata[KEY_W-1:0];
        end
        // A press landing with a clear of the same bit keeps the bit set.
        edge_d = (edge_q & ~w_edge_clr) | w_key_rise;
        irq_d  = |(edge_q & mask_q);
    end

    // Read mux; uses current register values so a same-cycle write is not
    // visible, and holds the last read data when no read is strobed.
    always_comb begin
        rdata_d = rdata_q;
        if (avs_read) begin
            rdata_d = '0;
            case (avs_address)
                ADDR_SW:   rdata_d[SW_W-1:0]  = sw_sync_q;
                ADDR_KEY:  rdata_d[KEY_W-1:0] = w_key_deb;
                ADDR_LED:  rdata_d[LED_W-1:0] = led_q;
                ADDR_EDGE: rdata_d[KEY_W-1:0] = edge_q;
                ADDR_MASK: rdata_d[KEY_W-1:0] = mask_q;
                default:   rdata_d            = '0;
            endcase
        end
    end

    // Register file, read data and interrupt state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_q   <= '0;
            edge_q  <= '0;
            mask_q  <= '0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            led_q   <= led_d;
            edge_q  <= edge_d;
            mask_q  <= mask_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
        end
    end

    assign avs_readdata = rdata_q;
    assign led          = led_q;
    assign irq          = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_avalon_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpio_avalon_ctrl
//  Description : Self-checking bench for gpio_avalon_ctrl: directed scenarios
//                plus randomized traffic against a window-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_avalon_ctrl;

    localparam int KEY_W = 4;
    localparam int SW_W  = 8;
    localparam int LED_W = 8;
    localparam int DEB   = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [2:0]        avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [31:0]       avs_readdata;
    logic [KEY_W-1:0]  key_n;
    logic [SW_W-1:0]   sw;
    logic [LED_W-1:0]  led;
    logic              irq;

    gpio_avalon_ctrl #(
        .KEY_W      (KEY_W),
        .SW_W       (SW_W),
        .LED_W      (LED_W),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .key_n         (key_n),
        .sw            (sw),
        .led           (led),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: raw inputs pass through a two-stage delay; a key's
    // debounced level is whatever the last DEB synchronized samples all agree on.
    logic [KEY_W-1:0] m_k1, m_k2, m_deb, m_edge, m_mask;
    logic [SW_W-1:0]  m_s1, m_s2;
    logic [LED_W-1:0] m_led;
    logic [31:0]      m_rd;
    logic             m_irq;
    logic [DEB-1:0]   m_hist [KEY_W];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_k1 = '1; m_k2 = '1; m_s1 = '0; m_s2 = '0;
        m_deb = '0; m_edge = '0; m_mask = '0; m_led = '0;
        m_rd = '0; m_irq = 1'b0;
        for (int i = 0; i < KEY_W; i++) m_hist[i] = '0;
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0:    return 32'(m_s2);
            3'd1:    return 32'(m_deb);
            3'd2:    return 32'(m_led);
            3'd3:    return 32'(m_edge);
            3'd4:    return 32'(m_mask);
            default: return 32'h0;
        endcase
    endfunction

    // One clock: predict from the current inputs, advance, then compare.
    task automatic tick();
        logic [KEY_W-1:0] pr, deb_n, press, clr, edge_n, mask_n;
        logic [LED_W-1:0] led_n;
        logic [31:0]      rd_n;
        logic             irq_n;
        logic [DEB-1:0]   h [KEY_W];
        pr    = ~m_k2;
        rd_n  = avs_read ? model_read(avs_address) : m_rd;
        irq_n = |(m_edge & m_mask);
        deb_n = m_deb;
        for (int i = 0; i < KEY_W; i++) begin
            h[i] = {m_hist[i][DEB-2:0], pr[i]};
            if (h[i] == '1)      deb_n[i] = 1'b1;
            else if (h[i] == '0) deb_n[i] = 1'b0;
        end
        press  = deb_n & ~m_deb;
        clr    = (avs_write && avs_address == 3'd3) ? avs_writedata[KEY_W-1:0] : '0;
        edge_n = (m_edge & ~clr) | press;
        mask_n = (avs_write && avs_address == 3'd4) ? avs_writedata[KEY_W-1:0] : m_mask;
        led_n  = m_led;
        if (avs_write && avs_address == 3'd2) led_n = avs_writedata[LED_W-1:0];
        if (avs_write && avs_address == 3'd5) led_n = m_led ^ avs_writedata[LED_W-1:0];
        @(posedge clk);
        #1;
        m_s2 = m_s1; m_s1 = sw;
        m_k2 = m_k1; m_k1 = key_n;
        for (int i = 0; i < KEY_W; i++) m_hist[i] = h[i];
        m_deb = deb_n; m_edge = edge_n; m_mask = mask_n; m_led = led_n;
        m_rd = rd_n; m_irq = irq_n;
        check("led", 32'(led), 32'(m_led));
        check("irq", 32'(irq), 32'(m_irq));
        check("readdata", avs_readdata, m_rd);
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        tick();
        avs_write = 1'b0;
    endtask

    task automatic do_read(input logic [2:0] a);
        avs_address = a; avs_read = 1'b1;
        tick();
        avs_read = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset_n = 1'b0; key_n = '1; sw = '0;
        avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_led", 32'(led), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        check("reset_readdata", avs_readdata, 32'h0);
        reset_n = 1'b1;

        // LED set, toggle, write-only and unmapped reads, read-during-write
        do_write(3'd2, 32'h0000_000F);
        do_write(3'd5, 32'hFFFF_FFFF);
        check("led_toggle", 32'(led), 32'hF0);
        do_read(3'd5);
        check("read_tgl_zero", avs_readdata, 32'h0);
        do_read(3'd7);
        check("read_addr7_zero", avs_readdata, 32'h0);
        avs_address = 3'd2; avs_writedata = 32'h55; avs_read = 1'b1; avs_write = 1'b1;
        tick();
        avs_read = 1'b0; avs_write = 1'b0;
        check("rw_same_old", avs_readdata, 32'hF0);
        check("rw_same_led", 32'(led), 32'h55);

        // Switch synchronizer latency
        sw = 8'h3C;
        do_read(3'd0);
        check("sw_early1", avs_readdata, 32'h0);
        do_read(3'd0);
        check("sw_early2", avs_readdata, 32'h0);
        do_read(3'd0);
        check("sw_value", avs_readdata, 32'h0000_003C);

        // Key 1 glitches shorter than the window never register
        for (int g = 0; g < 2; g++) begin
            key_n = 4'b1101;
            for (int c = 0; c < 3; c++) begin
                do_read(3'd1);
                check("key_glitch", avs_readdata, 32'h0);
            end
            key_n = 4'b1111;
            do_read(3'd1);
            check("key_glitch", avs_readdata, 32'h0);
        end
        key_n = 4'b1101;
        for (int c = 0; c < 6; c++) begin
            do_read(3'd1);
            check("key_settling", avs_readdata, 32'h0);
        end
        do_read(3'd1);
        check("key_debounced", avs_readdata, 32'h2);
        do_read(3'd3);
        check("edge_set", avs_readdata, 32'h2);

        // Interrupt enable, clear, and masked edge
        do_write(3'd4, 32'h2);
        idle(1);
        check("irq_asserted", 32'(irq), 32'h1);
        do_write(3'd3, 32'h2);
        idle(1);
        check("irq_cleared", 32'(irq), 32'h0);
        do_read(3'd3);
        check("edge_cleared", avs_readdata, 32'h0);
        idle(8);
        do_read(3'd3);
        check("edge_once", avs_readdata, 32'h0);
        key_n = 4'b1111;
        idle(8);
        do_write(3'd4, 32'h0);
        key_n = 4'b1101;
        idle(8);
        check("irq_masked", 32'(irq), 32'h0);
        do_read(3'd3);
        check("edge_masked", avs_readdata, 32'h2);

        // Press of key 0 coincides with a clear of EDGE[0]
        key_n = 4'b1100;
        idle(5);
        do_write(3'd3, 32'h1);
        do_read(3'd3);
        check("w1c_race", avs_readdata & 32'h1, 32'h1);
        key_n = 4'b1111;
        idle(8);
        do_write(3'd3, 32'hF);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            int op;
            for (int i = 0; i < KEY_W; i++)
                if ($urandom_range(0, 5) == 0) key_n[i] = ~key_n[i];
            if ($urandom_range(0, 15) == 0) sw = SW_W'($urandom);
            op            = int'($urandom_range(0, 3));
            avs_address   = 3'($urandom_range(0, 7));
            avs_read      = (op == 1) || (op == 3);
            avs_write     = (op == 2) || (op == 3);
            avs_writedata = $urandom;
            tick();
        end
        avs_read = 1'b0; avs_write = 1'b0;

        // Asynchronous reset mid-operation with a key held through it
        do_write(3'd2, 32'hA5);
        check("led_a5", 32'(led), 32'hA5);
        key_n = 4'b1011;
        do_write(3'd4, 32'hF);
        idle(8);
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async_led", 32'(led), 32'h0);
        check("async_irq", 32'(irq), 32'h0);
        check("async_readdata", avs_readdata, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        do_read(3'd2);
        check("post_reset_led_reg", avs_readdata, 32'h0);
        for (int c = 0; c < 5; c++) begin
            do_read(3'd1);
            check("post_reset_key_wait", avs_readdata, 32'h0);
        end
        do_read(3'd1);
        check("post_reset_key", avs_readdata, 32'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
